// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and elaboration helpers for the wait-state SRAM model.
//   state_e          : controller state (IDLE accepts, BUSY counts wait states)
//   cnt_width()      : clog2 with a floor of one bit (wait counter / word index)
//   wait_cycles_ok() : WAIT_CYCLES must be at least 1
//   data_w_ok()      : data width must be whole bytes when byte masking is built
//   idx_fits()       : word index must fit inside the address port
// -----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // clog2(n) but never narrower than one bit, so WAIT_CYCLES=1 still
    // gets a real (always-zero) counter register.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w < 32'd1) begin
            w = 32'd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    function automatic bit wait_cycles_ok(input int unsigned n);
        return (n >= 32'd1);
    endfunction

    function automatic bit data_w_ok(input int unsigned w);
        return ((w % 32'd8) == 32'd0);
    endfunction

    function automatic bit idx_fits(input int unsigned idx_w, input int unsigned addr_w);
        return (idx_w <= addr_w);
    endfunction

endpackage : sram_pkg

// File: rtl/sram_array.sv
// -----------------------------------------------------------------------------
// sram_array
// Single-port word storage: synchronous write with byte-lane mask and a
// registered read port. Storage itself is never reset; only the read register
// is. The read register changes only on a read or a clear, so it holds the
// last completed read across writes and idle cycles.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset (read register only)
//   we_i          : write the addressed word this edge (masked by be_i)
//   re_i          : capture the addressed word into rdata_o this edge
//   rclr_i        : load zero into rdata_o this edge (out-of-range read)
//   idx_i         : word index, caller guarantees idx_i < DEPTH when enabled
//   wdata_i       : write data
//   be_i          : byte-lane enables, one bit per 8 data bits
//   rdata_o       : registered read data
// -----------------------------------------------------------------------------
module sram_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned IDX_W  = 9,
    parameter int unsigned NB     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              rclr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [NB-1:0]     be_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] bitmask_s;
    logic [DATA_W-1:0] rdata_q;

    // Each data bit follows the enable of the byte lane it belongs to.
    for (genvar g = 0; g < DATA_W; g++) begin : g_mask
        assign bitmask_s[g] = be_i[g / 8];
    end

    // Storage write: only enabled lanes change, other lanes keep old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= (mem_q[idx_i] & ~bitmask_s) | (wdata_i & bitmask_s);
        end
    end

    // Registered read port; clear has priority so out-of-range reads return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (rclr_i) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : sram_array

// File: rtl/sram_wait_ctrl.sv
// -----------------------------------------------------------------------------
// sram_wait_ctrl
// Cycle-accurate SRAM with programmable wait states and a req/ready handshake.
// An access accepted at edge T completes at edge T+WAIT_CYCLES; the response
// pulse (rvalid or wdone, plus err when out of range) is high in the cycle
// after that edge, and ready rises on the same completion edge.
//
// Build option: define SRAM_BYTE_MASK_EN to add the `be` port and per-lane
// write masking. Without it every write updates the full word.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset; abandons any access in flight
//   req     in   access request, taken when ready=1
//   we_n    in   0 = write, 1 = read
//   addr    in   word address (ADDR_W bits)
//   wdata   in   write data (DATA_W bits)
//   be      in   byte-lane write enables (SRAM_BYTE_MASK_EN only)
//   ready   out  idle, next req will be accepted
//   rdata   out  last completed read data (zero for out-of-range reads)
//   rvalid  out  one-cycle read completion pulse
//   wdone   out  one-cycle write completion pulse
//   err     out  one-cycle pulse with rvalid/wdone when addr >= DEPTH
// -----------------------------------------------------------------------------
module sram_wait_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we_n,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
`ifdef SRAM_BYTE_MASK_EN
    input  logic [DATA_W/8-1:0] be,
`endif
    output logic                ready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                wdone,
    output logic                err
);

    localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);
    localparam int unsigned IDX_W = cnt_width(DEPTH);
    localparam int unsigned NB    = (DATA_W + 32'd7) / 32'd8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    // Elaboration-time parameter legality.
    if (!wait_cycles_ok(WAIT_CYCLES)) begin : g_bad_wait
        $error("sram_wait_ctrl: WAIT_CYCLES must be >= 1");
    end
    if (!idx_fits(IDX_W, ADDR_W)) begin : g_bad_addr
        $error("sram_wait_ctrl: ADDR_W too narrow for DEPTH");
    end
`ifdef SRAM_BYTE_MASK_EN
    if (!data_w_ok(DATA_W)) begin : g_bad_data
        $error("sram_wait_ctrl: DATA_W must be a multiple of 8 with byte masking");
    end
`endif

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;
    logic              ready_q;
    logic              rvalid_q;
    logic              wdone_q;
    logic              err_q;

    logic [NB-1:0]     be_s;
    logic              done_s;
    logic              in_range_s;
    logic              arr_we_s;
    logic              arr_re_s;
    logic              arr_clr_s;
    logic [DATA_W-1:0] arr_rdata_s;

`ifdef SRAM_BYTE_MASK_EN
    assign be_s = be;
`else
    assign be_s = {NB{1'b1}};
`endif

    // The access happens on the edge where BUSY sees an exhausted counter.
    assign done_s     = (state_q == ST_BUSY) && (cnt_q == {CNT_W{1'b0}});
    assign in_range_s = (64'(addr_q) < 64'(DEPTH));
    assign arr_we_s   = done_s && !we_n_q && in_range_s;
    assign arr_re_s   = done_s &&  we_n_q && in_range_s;
    assign arr_clr_s  = done_s &&  we_n_q && !in_range_s;

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .NB     (NB)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (arr_we_s),
        .re_i    (arr_re_s),
        .rclr_i  (arr_clr_s),
        .idx_i   (addr_q[IDX_W-1:0]),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .rdata_o (arr_rdata_s)
    );

    // Handshake FSM: accept in IDLE, count wait states in BUSY, pulse on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            we_n_q   <= 1'b1;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            be_q     <= {NB{1'b0}};
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_n_q  <= we_n;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        be_q    <= be_s;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_BUSY;
                        ready_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // req is ignored here; the requester must hold it until ready.
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b1;
                        rvalid_q <= we_n_q;
                        wdone_q  <= !we_n_q;
                        err_q    <= !in_range_s;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    cnt_q   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign rdata  = arr_rdata_s;
    assign rvalid = rvalid_q;
    assign wdone  = wdone_q;
    assign err    = err_q;

endmodule : sram_wait_ctrl

// File: doc/sram_wait_ctrl.md
# sram_wait_ctrl

Parametrised, cycle-accurate SRAM model with programmable wait states and a request/ready handshake. It replaces the fixed 32-bit, 512-word, delay-annotated SRAM used by the memory stage. Width, depth and access latency are set by parameters. Read and write completion are signalled explicitly, so the memory-stage controller can stall on `ready` instead of relying on analog delays.

## Interface
- `DATA_W`, 32, data word width in bits
- `ADDR_W`, 17, address width in bits
- `DEPTH`, 512, number of words implemented
- `WAIT_CYCLES`, 3, clock edges from accept to completion; ≥1
- `clk`  in  1  clock, all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req`  in  1  access request, sampled when `ready`=1
- `we_n`  in  1  0 = write, 1 = read; sampled with `req`
- `addr`  in  ADDR_W  word address; sampled with `req`
- `wdata`  in  DATA_W  write data; sampled with `req`
- `be`  in  DATA_W/8  byte-lane write enables; present only with SRAM_BYTE_MASK_EN
- `ready`  out  1  block idle and able to accept `req`
- `rdata`  out  DATA_W  read data; holds last completed read
- `rvalid`  out  1  one-cycle pulse, `rdata` valid
- `wdone`  out  1  one-cycle pulse, write committed
- `err`  out  1  one-cycle pulse with `rvalid`/`wdone` when `addr` ≥ DEPTH

## Operation
- States: IDLE (`ready`=1) and BUSY (`ready`=0).
- IDLE with `req`=1 at an edge:
  - latch `we_n`, `addr`, `wdata` (and `be`)
  - load wait counter with WAIT_CYCLES-1
  - go to BUSY
- BUSY, counter ≠ 0: decrement at each edge.
- BUSY, counter = 0, at the next edge, perform the access and return to IDLE:
  - write: update the array; pulse `wdone`
  - read: register array word into `rdata`; pulse `rvalid`
- `req` while BUSY: ignored. No queueing, no error.
- Out-of-range (`addr` ≥ DEPTH): normal timing.
  - write: discarded
  - read: returns all-zero `rdata`
  - `err` pulses alongside `rvalid`/`wdone`
- Array contents are not reset and are undefined until written.
- Counter width: clog2(WAIT_CYCLES), minimum 1 bit.

## Timing
- Accept at edge T. Completion edge is T+WAIT_CYCLES. `rvalid`/`wdone`/`err` are high in the cycle following that edge.
- `ready` rises on the completion edge, coincident with the response pulse.
- Next accept is possible at edge T+WAIT_CYCLES+1, so throughput is one access per WAIT_CYCLES+1 cycles.
- WAIT_CYCLES=1: accept at T, response visible after T+1.
- Reset values: state IDLE, `ready` 1, `rdata` 0, `rvalid` 0, `wdone` 0, `err` 0, counter 0.
- Reset asserted mid-access: the access is abandoned, the write is not committed, and the array is unchanged. No response pulse is produced.
- Read-after-write to the same address on back-to-back accesses returns the new data.

## Configuration
- `SRAM_BYTE_MASK_EN` defined:
  - `be` port exists; requires DATA_W to be a multiple of 8
  - a write updates only lanes whose `be` bit is 1
  - `be`=0 still completes with `wdone`
- `SRAM_BYTE_MASK_EN` undefined:
  - `be` port absent
  - every write updates the full word
- Reads are identical in both cases.

## Structure
- Package `sram_pkg` holds:
  - state enum (IDLE, BUSY)
  - counter-width function (clog2 with floor 1)
  - parameter-legality checks (WAIT_CYCLES ≥ 1; DATA_W%8 = 0 under the macro)
- Sub-module `sram_array` holds storage with a single port: synchronous write with lane mask, registered read.
- The FSM, counter, range check and response pulses stay in the top module.

## Test plan
- Reset, then WAIT_CYCLES=3: write 0xDEADBEEF to addr 5, accepted at edge T → `wdone` high the cycle after T+3; `ready`=0 during T+1..T+3.
- Read addr 5 immediately after the write completes → `rdata`=0xDEADBEEF with `rvalid` after 3 edges; `err`=0.
- Read addr 512 with DEPTH=512 → `rdata`=0, `rvalid`=1, `err`=1. A write to addr 600 leaves all in-range words unchanged.
- `req` held high across a BUSY period with differing `addr` → only the first request is serviced; the second is accepted at the first edge where `ready`=1.
- With SRAM_BYTE_MASK_EN: word 0x11223344 at addr 2; write 0xAABBCCDD with `be`=4'b0101 → a later read returns 0x11BB33DD.
- Reset pulsed low two cycles into a write to addr 7 (previously 0x0) → no `wdone`; `ready`=1 during reset; a later read of addr 7 returns 0x0.
